// File: rtl/demux_8_tdm_pkg.sv
// Shared constants for the 8-slot TDM receive demultiplexer.
package demux_8_tdm_pkg;
   localparam int NUM_SLOTS = 8;
   localparam int SLOT_W    = 3;
endpackage

// File: rtl/demux_8_tdm_demux_1_8.sv
// 1-to-8 one-hot decoder producing per-slot write enables.
module demux_1_8
   import demux_8_tdm_pkg::*;
(
   input  logic [SLOT_W-1:0]    sel,
   input  logic                 en,
   output logic [NUM_SLOTS-1:0] onehot
);

   always_comb begin
      onehot = '0;
      if (en) onehot[sel] = 1'b1;
   end

endmodule

// File: rtl/demux_8_tdm.sv
// TDM demultiplexer: assembles 8-slot frames from a serial word stream into a
// single-entry output buffer with valid/ready handshake.
module demux_8_tdm
   import demux_8_tdm_pkg::*;
#(
   parameter int W = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [W-1:0]          d,
   input  logic                  d_valid,
   input  logic                  sof,
   output logic [NUM_SLOTS*W-1:0] y,
   output logic                  y_valid,
   input  logic                  y_ready,
   output logic [SLOT_W-1:0]     slot,
   output logic                  overrun,
   output logic                  sync_err
);

   // Slot 7 is never stored: it goes straight into y together with slots 0..6.
   logic [W-1:0]           asm_q [NUM_SLOTS-1];
   logic [W-1:0]           asm_d [NUM_SLOTS-1];
   logic [SLOT_W-1:0]      slot_q, slot_d;
   logic [NUM_SLOTS*W-1:0] y_q, y_d;
   logic                   y_valid_q, y_valid_d;
   logic                   overrun_q, overrun_d;
   logic                   sync_err_q, sync_err_d;

   logic [SLOT_W-1:0]      sel;
   logic [NUM_SLOTS-1:0]   we;
   logic                   out_free;

   assign sel = sof ? '0 : slot_q;

   demux_1_8 u_dec (
      .sel    (sel),
      .en     (d_valid),
      .onehot (we)
   );

   assign out_free = !y_valid_q || y_ready;

   always_comb begin
      asm_d      = asm_q;
      slot_d     = slot_q;
      y_d        = y_q;
      y_valid_d  = y_valid_q;
      overrun_d  = 1'b0;
      sync_err_d = 1'b0;

      for (int k = 0; k < NUM_SLOTS - 1; k++) begin
         if (we[k]) asm_d[k] = d;
      end

      if (d_valid) begin
         if (sof) begin
            slot_d     = SLOT_W'(1);
            sync_err_d = (slot_q != '0);
         end else begin
            slot_d = slot_q + SLOT_W'(1);
         end
      end

      if (y_valid_q && y_ready) y_valid_d = 1'b0;

      // we[7] can only be set by a non-sof word landing in the last slot.
      if (we[NUM_SLOTS-1]) begin
         if (out_free) begin
            for (int k = 0; k < NUM_SLOTS - 1; k++) y_d[k*W +: W] = asm_q[k];
            y_d[(NUM_SLOTS-1)*W +: W] = d;
            y_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_SLOTS - 1; k++) asm_q[k] <= '0;
         slot_q     <= '0;
         y_q        <= '0;
         y_valid_q  <= 1'b0;
         overrun_q  <= 1'b0;
         sync_err_q <= 1'b0;
      end else begin
         asm_q      <= asm_d;
         slot_q     <= slot_d;
         y_q        <= y_d;
         y_valid_q  <= y_valid_d;
         overrun_q  <= overrun_d;
         sync_err_q <= sync_err_d;
      end
   end

   assign y        = y_q;
   assign y_valid  = y_valid_q;
   assign slot     = slot_q;
   assign overrun  = overrun_q;
   assign sync_err = sync_err_q;

endmodule

// File: tb/tb_demux_8_tdm.sv
// Self-checking bench for demux_8_tdm (W=4): directed scenarios then random traffic
// against a queue-based frame model.
module tb_demux_8_tdm;
   localparam int W = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [W-1:0]  d = '0;
   logic          d_valid = 1'b0;
   logic          sof = 1'b0;
   logic          y_ready = 1'b0;
   logic [8*W-1:0] y;
   logic          y_valid;
   logic [2:0]    slot;
   logic          overrun;
   logic          sync_err;

   int total = 0;
   int bad   = 0;

   // reference model state
   int             q[$];
   logic [8*W-1:0] m_y = '0;
   logic           m_yv = 1'b0;
   logic           m_ovr = 1'b0;
   logic           m_serr = 1'b0;

   demux_8_tdm #(.W(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .d        (d),
      .d_valid  (d_valid),
      .sof      (sof),
      .y        (y),
      .y_valid  (y_valid),
      .y_ready  (y_ready),
      .slot     (slot),
      .overrun  (overrun),
      .sync_err (sync_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".y"},        64'(y),        64'(m_y));
      chk({tag, ".y_valid"},  64'(y_valid),  64'(m_yv));
      chk({tag, ".slot"},     64'(slot),     64'(q.size()));
      chk({tag, ".overrun"},  64'(overrun),  64'(m_ovr));
      chk({tag, ".sync_err"}, 64'(sync_err), 64'(m_serr));
   endtask

   task automatic model_reset();
      q.delete();
      m_y = '0; m_yv = 1'b0; m_ovr = 1'b0; m_serr = 1'b0;
   endtask

   // One clock: drive inputs, predict, clock, then compare.
   task automatic step(input string tag, input int dw, input bit dv, input bit sf, input bit rdy);
      bit free;
      @(negedge clk);
      d = dw[W-1:0]; d_valid = dv; sof = sf; y_ready = rdy;
      m_ovr = 1'b0; m_serr = 1'b0;
      free = !m_yv || rdy;
      if (m_yv && rdy) m_yv = 1'b0;
      if (dv) begin
         if (sf) begin
            if (q.size() != 0) m_serr = 1'b1;
            q.delete();
         end
         q.push_back(dw & ((1 << W) - 1));
         if (q.size() == 8) begin
            if (free) begin
               for (int k = 0; k < 8; k++) m_y[k*W +: W] = q[k][W-1:0];
               m_yv = 1'b1;
            end else begin
               m_ovr = 1'b1;
            end
            q.delete();
         end
      end
      @(posedge clk);
      #1;
      chk_all(tag);
   endtask

   initial begin
      model_reset();
      #12;
      chk_all("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // basic frame
      for (int i = 0; i < 8; i++) step("basic", i, 1'b1, i == 0, 1'b1);
      chk("basic_lit_y", 64'(y), 64'h76543210);
      chk("basic_lit_yv", 64'(y_valid), 64'd1);

      // gapped input
      for (int i = 0; i < 8; i++) begin
         step("gap_word", i, 1'b1, i == 0, 1'b1);
         if (i != 7) begin
            step("gap_idle", 4'hA, 1'b0, 1'b1, 1'b1);
            step("gap_idle", 4'h5, 1'b0, 1'b0, 1'b1);
         end
      end
      chk("gap_lit_y", 64'(y), 64'h76543210);
      step("gap_drain", 0, 1'b0, 1'b0, 1'b1);

      // backpressure: A accepted, B overruns
      for (int i = 0; i < 16; i++) step("bp", i, 1'b1, (i % 8) == 0, 1'b0);
      chk("bp_lit_ovr", 64'(overrun), 64'd1);
      chk("bp_lit_y", 64'(y), 64'h76543210);
      step("bp_hold", 0, 1'b0, 1'b0, 1'b0);

      // simultaneous transfer and load
      for (int i = 8; i < 16; i++) step("simul", i, 1'b1, i == 8, i == 15);
      chk("simul_lit_y", 64'(y), 64'hFEDCBA98);
      chk("simul_lit_ovr", 64'(overrun), 64'd0);
      step("simul_drain", 0, 1'b0, 1'b0, 1'b1);

      // misalignment
      for (int i = 0; i < 5; i++) step("mis_pre", i + 3, 1'b1, i == 0, 1'b1);
      step("mis_sof", 9, 1'b1, 1'b1, 1'b1);
      chk("mis_lit_serr", 64'(sync_err), 64'd1);
      chk("mis_lit_slot", 64'(slot), 64'd1);
      for (int i = 1; i < 8; i++) step("mis_post", i, 1'b1, 1'b0, 1'b1);
      chk("mis_lit_y", 64'(y), 64'h76543219);

      // sof at slot 7 realigns without completing
      for (int i = 0; i < 7; i++) step("s7_pre", i, 1'b1, i == 0, 1'b1);
      step("s7_sof", 2, 1'b1, 1'b1, 1'b1);
      for (int i = 1; i < 8; i++) step("s7_post", 15 - i, 1'b1, 1'b0, 1'b1);

      // mid-frame async reset
      for (int i = 0; i < 8; i++) step("rst_fill", i + 1, 1'b1, i == 0, 1'b0);
      for (int i = 0; i < 4; i++) step("rst_part", i, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      d_valid = 1'b0; sof = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk_all("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) step("post_rst", 7 - i, 1'b1, 1'b0, 1'b1);
      chk("post_rst_lit_y", 64'(y), 64'h01234567);

      // random traffic
      for (int n = 0; n < 600; n++) begin
         step("rand", int'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
              $urandom_range(0, 11) == 0, $urandom_range(0, 2) != 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
